// File: rtl/culsans_pkg.sv
// Shared definitions for the culsans SoC slice: peripheral base addresses,
// end-of-test controller register offsets and its state encoding.
package culsans_pkg;

  localparam logic [31:0] ExitBase     = 32'h0030_0000;

  localparam logic [11:0] ExitCoreBase = 12'h000;
  localparam logic [11:0] ExitStatus   = 12'h100;
  localparam logic [11:0] ExitForce    = 12'h104;
  localparam logic [11:0] ExitCycleLo  = 12'h108;
  localparam logic [11:0] ExitCycleHi  = 12'h10C;

  typedef enum logic [0:0] {
    EXIT_RUN  = 1'b0,
    EXIT_DONE = 1'b1
  } exit_state_e;

endpackage

// File: rtl/culsans_exit_ctrl_if.sv
// Register-bus bundle of the end-of-test controller: request/grant with a
// one-cycle registered response.
interface culsans_exit_ctrl_if #(
  parameter int unsigned AddrWidth = 12
);
  logic                 req_i;
  logic                 we_i;
  logic [AddrWidth-1:0] addr_i;
  logic [31:0]          wdata_i;
  logic [3:0]           be_i;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [31:0]          rdata_o;
  logic                 err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/culsans_exit_ctrl.sv
// End-of-test controller: collects per-core exit reports, latches one exit
// word for the top-level port and keeps a 64-bit cycle counter frozen at exit.
module culsans_exit_ctrl
  import culsans_pkg::*;
#(
  parameter int unsigned NumCores  = 2,
  parameter int unsigned AddrWidth = 12
) (
  input  logic               clk_i,
  input  logic               rst,
  culsans_exit_ctrl_if.slave bus,
  output logic [31:0]        exit_o
);

  localparam int unsigned WordWidth = AddrWidth - 2;

  exit_state_e         state_r, state_nxt_s;
  logic [NumCores-1:0] done_r, done_nxt_s;
  logic [30:0]         code_r     [NumCores];
  logic [30:0]         code_nxt_s [NumCores];
  logic [63:0]         cnt_r;
  logic [31:0]         shadow_r, shadow_nxt_s;
  logic [31:0]         exit_r, exit_nxt_s;
  logic                rvalid_r;
  logic                err_r, err_nxt_s;
  logic [31:0]         rdata_r, rdata_nxt_s;

  logic [WordWidth-1:0] word_s;
  logic                 aligned_s;
  logic [NumCores-1:0]  sel_s;
  logic                 core_hit_s;
  logic                 full_be_s;
  logic                 any_code_s;
  logic [31:0]          core_word_s;
  logic [31:0]          status_s;
  logic                 hit_status_s, hit_force_s, hit_lo_s, hit_hi_s;

  assign word_s       = bus.addr_i[AddrWidth-1:2];
  assign aligned_s    = (bus.addr_i[1:0] == 2'b00);
  assign full_be_s    = (bus.be_i == 4'hF);
  assign hit_status_s = (bus.addr_i == AddrWidth'(ExitStatus));
  assign hit_force_s  = (bus.addr_i == AddrWidth'(ExitForce));
  assign hit_lo_s     = (bus.addr_i == AddrWidth'(ExitCycleLo));
  assign hit_hi_s     = (bus.addr_i == AddrWidth'(ExitCycleHi));
  assign core_hit_s   = |sel_s;

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_r;
  assign bus.rdata_o  = rdata_r;
  assign bus.err_o    = err_r;
  assign exit_o       = exit_r;

  // Only the first 32 done bits are visible through STATUS.
  if (NumCores <= 32) begin : g_status_narrow
    assign status_s = 32'(done_r);
  end else begin : g_status_wide
    assign status_s = done_r[31:0];
  end

  // Per-core register select and read-back mux
  always_comb begin
    sel_s       = '0;
    core_word_s = 32'h0000_0000;
    for (int i = 0; i < NumCores; i++) begin
      if (aligned_s && (word_s == WordWidth'(i))) begin
        sel_s[i]    = 1'b1;
        core_word_s = {code_r[i], done_r[i]};
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Bus decode, register updates and exit decision
  always_comb begin
    state_nxt_s  = state_r;
    done_nxt_s   = done_r;
    code_nxt_s   = code_r;
    exit_nxt_s   = exit_r;
    shadow_nxt_s = shadow_r;
    err_nxt_s    = 1'b0;
    rdata_nxt_s  = 32'h0000_0000;
    any_code_s   = 1'b0;
    if (bus.req_i && bus.we_i) begin
      if (state_r == EXIT_DONE) begin
        err_nxt_s = 1'b0;
      end else if (core_hit_s) begin
        if (!full_be_s) begin
          err_nxt_s = 1'b1;
        end else if (bus.wdata_i[0]) begin
          done_nxt_s = done_r | sel_s;
          for (int i = 0; i < NumCores; i++) begin
            if (sel_s[i]) begin
              code_nxt_s[i] = bus.wdata_i[31:1];
            end else begin
              code_nxt_s[i] = code_r[i];
            end
            any_code_s = any_code_s | (code_nxt_s[i] != 31'h0);
          end
          // A nonzero code exits at once; a clean exit waits for every core.
          if (bus.wdata_i[31:1] != 31'h0) begin
            state_nxt_s = EXIT_DONE;
            exit_nxt_s  = {bus.wdata_i[31:1], 1'b1};
          end else if ((&done_nxt_s) && !any_code_s) begin
            state_nxt_s = EXIT_DONE;
            exit_nxt_s  = 32'h0000_0001;
          end else begin
            state_nxt_s = EXIT_RUN;
          end
        end else begin
          done_nxt_s = done_r;
        end
      end else if (hit_force_s) begin
        if (!full_be_s) begin
          err_nxt_s = 1'b1;
        end else if (bus.wdata_i[0]) begin
          state_nxt_s = EXIT_DONE;
          exit_nxt_s  = bus.wdata_i;
        end else begin
          state_nxt_s = EXIT_RUN;
        end
      end else begin
        err_nxt_s = 1'b1;
      end
    end else if (bus.req_i) begin
      if (core_hit_s) begin
        rdata_nxt_s = core_word_s;
      end else if (hit_status_s) begin
        rdata_nxt_s = status_s;
      end else if (hit_lo_s) begin
        rdata_nxt_s  = cnt_r[31:0];
        shadow_nxt_s = cnt_r[63:32];
      end else if (hit_hi_s) begin
        rdata_nxt_s = shadow_r;
      end else begin
        err_nxt_s = 1'b1;
      end
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end
  end

  // Control state, exit word and per-core exit registers
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_r  <= EXIT_RUN;
      done_r   <= '0;
      code_r   <= '{default: 31'h0};
      exit_r   <= 32'h0000_0000;
      shadow_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      done_r   <= done_nxt_s;
      code_r   <= code_nxt_s;
      exit_r   <= exit_nxt_s;
      shadow_r <= shadow_nxt_s;
    end
  end

  // Free-running cycle counter, frozen once exited
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      cnt_r <= 64'h0;
    end else if (state_r == EXIT_RUN) begin
      cnt_r <= cnt_r + 64'h1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered bus response, one cycle after grant
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      rvalid_r <= bus.req_i;
      err_r    <= err_nxt_s;
      rdata_r  <= rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_culsans_exit_ctrl.sv
// Directed bench for culsans_exit_ctrl: a vector table for the register map
// plus hand-written sequences for exit, counter and asynchronous reset.
module tb_culsans_exit_ctrl;
  import culsans_pkg::*;

  localparam int unsigned AW = 12;

  typedef struct {
    string       name;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] exit_w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] exit_o;
  int          n_vec  = 0;
  int          n_miss = 0;
  vec_t        tbl[$];
  logic [31:0] lo_v, hi_v, lo2_v;

  culsans_exit_ctrl_if #(.AddrWidth(AW)) bus ();

  culsans_exit_ctrl #(.NumCores(2), .AddrWidth(AW)) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus),
    .exit_o(exit_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic we, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input logic err,
                              input logic [31:0] rdata, input logic [31:0] exit_w);
    vec_t v;
    v.name = nm; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.err = err; v.rdata = rdata; v.exit_w = exit_w;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the request dropped.
  task automatic apply(input vec_t v);
    bus.req_i = 1'b1; bus.we_i = v.we; bus.addr_i = v.addr;
    bus.wdata_i = v.wdata; bus.be_i = v.be;
    #1 chk({v.name, ".gnt"}, 64'(bus.gnt_o), 64'd1);
    @(negedge clk);
    chk({v.name, ".rvalid"}, 64'(bus.rvalid_o), 64'd1);
    chk({v.name, ".err"},    64'(bus.err_o),    64'(v.err));
    chk({v.name, ".rdata"},  64'(bus.rdata_o),  64'(v.rdata));
    chk({v.name, ".exit"},   64'(exit_o),       64'(v.exit_w));
    bus.req_i = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] addr, output logic [31:0] data);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = addr;
    bus.wdata_i = 32'h0; bus.be_i = 4'hF;
    @(negedge clk);
    chk({nm, ".rvalid"}, 64'(bus.rvalid_o), 64'd1);
    chk({nm, ".err"},    64'(bus.err_o),    64'd0);
    data = bus.rdata_o;
    bus.req_i = 1'b0;
  endtask

  task automatic reset_dut();
    bus.req_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
    bus.wdata_i = 32'h0; bus.be_i = 4'h0;
    #1;
    chk("rst.exit",   64'(exit_o),       64'd0);
    chk("rst.rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("rst.err",    64'(bus.err_o),    64'd0);
    chk("rst.rdata",  64'(bus.rdata_o),  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    tbl.push_back(mk("t0_rd_core0",    1'b0, 12'h000, 32'h0,  4'hF, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk("t1_rd_status",   1'b0, 12'h100, 32'h0,  4'hF, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk("t2_wr_core0",    1'b1, 12'h000, 32'h1,  4'hF, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk("t3_rd_status",   1'b0, 12'h100, 32'h0,  4'hF, 1'b0, 32'h1, 32'h0));
    tbl.push_back(mk("t4_rd_core0",    1'b0, 12'h000, 32'h0,  4'hF, 1'b0, 32'h1, 32'h0));
    tbl.push_back(mk("t5_wr_unmapped", 1'b1, 12'h200, 32'h1,  4'hF, 1'b1, 32'h0, 32'h0));
    tbl.push_back(mk("t6_wr_status",   1'b1, 12'h100, 32'h3,  4'hF, 1'b1, 32'h0, 32'h0));
    tbl.push_back(mk("t7_wr_core1_be", 1'b1, 12'h004, 32'h1,  4'h1, 1'b1, 32'h0, 32'h0));
    tbl.push_back(mk("t8_rd_force",    1'b0, 12'h104, 32'h0,  4'hF, 1'b1, 32'h0, 32'h0));
    tbl.push_back(mk("t9_rd_core2",    1'b0, 12'h008, 32'h0,  4'hF, 1'b1, 32'h0, 32'h0));
    tbl.push_back(mk("t10_wr_core1_0", 1'b1, 12'h004, 32'h0,  4'hF, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk("t11_rd_status",  1'b0, 12'h100, 32'h0,  4'hF, 1'b0, 32'h1, 32'h0));
    tbl.push_back(mk("t12_rd_core1",   1'b0, 12'h004, 32'h0,  4'hF, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk("t13_wr_core1",   1'b1, 12'h004, 32'h1,  4'hF, 1'b0, 32'h0, 32'h1));
    tbl.push_back(mk("t14_rd_status",  1'b0, 12'h100, 32'h0,  4'hF, 1'b0, 32'h3, 32'h1));
    tbl.push_back(mk("t15_wr_done",    1'b1, 12'h000, 32'h15, 4'hF, 1'b0, 32'h0, 32'h1));
    tbl.push_back(mk("t16_rd_core0",   1'b0, 12'h000, 32'h0,  4'hF, 1'b0, 32'h1, 32'h1));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    @(negedge clk);
    chk("idle.rvalid", 64'(bus.rvalid_o), 64'd0);

    // Nonzero code from one core exits without waiting for the other.
    reset_dut();
    apply(mk("b_wr_core1_15", 1'b1, 12'h004, 32'h15, 4'hF, 1'b0, 32'h0,  32'h15));
    apply(mk("b_rd_core1",    1'b0, 12'h004, 32'h0,  4'hF, 1'b0, 32'h15, 32'h15));
    apply(mk("b_wr_core0",    1'b1, 12'h000, 32'h1,  4'hF, 1'b0, 32'h0,  32'h15));
    apply(mk("b_rd_status",   1'b0, 12'h100, 32'h0,  4'hF, 1'b0, 32'h2,  32'h15));

    // Cycle counter: exact values relative to reset release, frozen after exit.
    reset_dut();
    repeat (10) @(negedge clk);
    rd("c_lo10", 12'h108, lo_v);
    chk("c_lo10.val", 64'(lo_v), 64'd10);
    rd("c_hi10", 12'h10C, hi_v);
    chk("c_hi10.val", 64'(hi_v), 64'd0);
    repeat (37) @(negedge clk);
    rd("c_lo49", 12'h108, lo_v);
    chk("c_lo49.val", 64'(lo_v), 64'd49);
    apply(mk("c_force7", 1'b1, 12'h104, 32'h7, 4'hF, 1'b0, 32'h0, 32'h7));
    rd("c_lo_done1", 12'h108, lo_v);
    chk("c_lo_done1.val", 64'(lo_v), 64'd51);
    rd("c_hi_done", 12'h10C, hi_v);
    chk("c_hi_done.val", 64'(hi_v), 64'd0);
    rd("c_lo_done2", 12'h108, lo2_v);
    chk("c_lo_frozen", 64'(lo2_v), 64'(lo_v));

    // Asynchronous reset in DONE drops exit_o before any clock edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst.exit",   64'(exit_o),       64'd0);
    chk("arst.rvalid", 64'(bus.rvalid_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rd("e_lo0", 12'h108, lo_v);
    chk("e_lo0.val", 64'(lo_v), 64'd0);
    rd("e_lo1", 12'h108, lo_v);
    chk("e_lo1.val", 64'(lo_v), 64'd1);
    apply(mk("e_rd_status",   1'b0, 12'h100, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0));
    apply(mk("e_force_bit0",  1'b1, 12'h104, 32'h6, 4'hF, 1'b0, 32'h0, 32'h0));
    apply(mk("e_force_be",    1'b1, 12'h104, 32'h7, 4'h7, 1'b1, 32'h0, 32'h0));
    apply(mk("e_wr_cyclo",    1'b1, 12'h108, 32'h1, 4'hF, 1'b1, 32'h0, 32'h0));
    apply(mk("e_force7",      1'b1, 12'h104, 32'h7, 4'hF, 1'b0, 32'h0, 32'h7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/culsans_exit_ctrl.md
# culsans_exit_ctrl

Memory-mapped end-of-test controller that produces the 32-bit `exit_o` word of `culsans_top`. Each core reports completion and a return code through its own register; the block aggregates the reports, latches a single exit word and drives it to the top-level port, where the bench waits for bit 0 and reads the code from bits [31:1]. A free-running 64-bit cycle counter, frozen at exit, supports performance runs.

## Interface
Parameters:
- `NumCores`, 2: number of per-core exit registers (1..64).
- `AddrWidth`, 12: register-bus byte address width.

Ports:
- `clk_i`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  bus request.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  AddrWidth  byte address, word aligned.
- `wdata_i`  in  32  write data.
- `be_i`  in  4  byte enables.
- `gnt_o`  out  1  grant.
- `rvalid_o`  out  1  response valid, reads and writes.
- `rdata_o`  out  32  read data.
- `err_o`  out  1  error, valid with `rvalid_o`.
- `exit_o`  out  32  latched exit word: bit 0 = done, bits [31:1] = code.

## Operation
Register map, byte offsets:
- 0x000 + 4·i, CORE_EXIT[i], RW.
  - Write with bit 0 = 1: sets done[i] and stores code[i] = wdata[31:1].
  - Write with bit 0 = 0: acknowledged, no state change.
  - Read returns {code[i], done[i]}.
- 0x100, STATUS, RO: done mask, zero-extended to 32 bits (NumCores ≤ 32 visible).
- 0x104, FORCE_EXIT, WO: write with bit 0 = 1 exits immediately with exit word = wdata_i.
- 0x108, CYCLE_LO, RO: returns counter[31:0] and snapshots counter[63:32] into a shadow register.
- 0x10C, CYCLE_HI, RO: returns the shadow register.

Error responses:
- Unmapped address, write to an RO register, or read of FORCE_EXIT: `err_o` = 1, `rdata_o` = 0, no state change.
- Write to CORE_EXIT/FORCE_EXIT with `be_i` ≠ 4'hF: error, write discarded.

FSM states: RUN, DONE.
- In RUN, a CORE_EXIT write with bit 0 = 1 and nonzero code goes to DONE with `exit_o` = {code, 1}.
- In RUN, when the accepted write makes every done bit 1 with all codes zero, go to DONE with `exit_o` = 32'h1.
- In RUN, a valid FORCE_EXIT goes to DONE with `exit_o` = wdata_i.
- DONE is absorbing until reset. `exit_o`, codes and the done mask are frozen. Further writes are acknowledged without error and ignored; reads still work.
- A rewrite by an already-done core in RUN overwrites code[i]. If the new code is nonzero, it exits.

Counter:
- 64 bits, increments every cycle in RUN, including the cycle of the exiting write.
- Holds in DONE.
- Wraps from 2^64−1 to 0.

## Timing
- `gnt_o` = `req_i`, combinational; every request is accepted in its cycle. There is one request per cycle, so core writes cannot collide.
- Response: `rvalid_o`, `rdata_o` and `err_o` are registered and appear exactly one cycle after the grant. `rvalid_o` is high for one cycle per request. Back-to-back requests give back-to-back responses.
- State and register updates take effect on the clock edge that accepts the write.
  - `exit_o` changes on that edge, so it is visible in the same cycle as the write's `rvalid_o`.
  - A read in the following cycle sees the new values.
- Reset values: `exit_o` = 0, `rvalid_o` = 0, `err_o` = 0, `rdata_o` = 0, `gnt_o` follows `req_i`. State = RUN; done, codes, counter and shadow = 0.
- Reset mid-run or in DONE clears everything asynchronously; `exit_o` drops to 0 without waiting for a clock edge.

## Structure
- Shared in `culsans_pkg`:
  - register offset localparams: `ExitCoreBase`, `ExitStatus`, `ExitForce`, `ExitCycleLo`, `ExitCycleHi`;
  - the state enum `exit_state_e` {EXIT_RUN, EXIT_DONE}.
- Single module with no sub-module. The counter is inline.
- Instantiated in `culsans_top` on the peripheral bus at `culsans_pkg::ExitBase`. Its `exit_o` drives the top-level `exit_o` directly.

## Test plan
- Core 0 writes 0x1, then core 1 writes 0x1 → after the second write `exit_o` = 0x00000001 and STATUS reads 0x3.
- Core 1 writes 0x0000_0015 (code 0xA) while core 0 is not done → `exit_o` = 0x15 immediately. A later core 0 write of 0x1 leaves `exit_o` at 0x15.
- Read CYCLE_LO/HI at 10 cycles after reset, then again after exit at 50 cycles → values increase monotonically. After exit two successive reads are identical. HI equals the snapshot taken at the LO read.
- Write 0x200 (unmapped), write STATUS, and write CORE_EXIT with `be_i` = 4'h1 → each gives `rvalid_o` + `err_o` one cycle later, with no change to `exit_o`.
- FORCE_EXIT write of 0x0000_0007 → `exit_o` = 0x7. Assert `rst` low asynchronously mid-cycle → `exit_o` = 0 at once; after release, state is RUN and the counter restarts from 0.
